// File: rtl/bus_arbiter_pkg.sv
// Shared definitions for the memory bus arbiter: bus width, default
// parameter values and the controller state encoding.
package bus_arbiter_pkg;

  localparam int BUS_W = 16;

  localparam int DEF_NUM_REQ      = 4;
  localparam int DEF_WAIT_STATES  = 1;
  localparam int DEF_CPU_PRIORITY = 1;
  localparam int DEF_MAX_BURST    = 4;

  localparam int WAIT_CNT_W  = 4;
  localparam int BURST_CNT_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_ACK    = 2'd2
  } state_e;

endpackage

// File: rtl/bus_arbiter_pick.sv
// Combinational rotating-priority picker: searches from last+1 upward with
// wrap, optionally letting requester 0 override the rotation.
module arbiter_pick #(
  parameter int NUM_REQ = 4,
  parameter int IW      = 2
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IW-1:0]      last_i,
  input  logic               cpu_priority_i,
  output logic [IW-1:0]      winner_o,
  output logic               valid_o
);

  int          candSum;
  logic [IW-1:0] cand;

  // Wrap is done by subtraction so a non-power-of-two NUM_REQ never
  // produces an index past the last requester.
  always_comb begin
    winner_o = '0;
    valid_o  = 1'b0;
    candSum  = 0;
    cand     = '0;
    if (cpu_priority_i && req_i[0]) begin
      valid_o = 1'b1;
    end else begin
      for (int k = 1; k <= NUM_REQ; k++) begin
        candSum = int'(last_i) + k;
        if (candSum >= NUM_REQ) candSum = candSum - NUM_REQ;
        cand = IW'(candSum);
        if (!valid_o && req_i[cand]) begin
          winner_o = cand;
          valid_o  = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// Shares the 16-bit memory bus between NUM_REQ masters (master 0 = Cpu),
// inserting fixed wait states and supporting capped locked bursts.
module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter int NUM_REQ      = DEF_NUM_REQ,
  parameter int WAIT_STATES  = DEF_WAIT_STATES,
  parameter int CPU_PRIORITY = DEF_CPU_PRIORITY,
  parameter int MAX_BURST    = DEF_MAX_BURST
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ-1:0]       lock,
  input  logic [NUM_REQ-1:0]       we,
  input  logic [BUS_W*NUM_REQ-1:0] addr,
  input  logic [BUS_W*NUM_REQ-1:0] wdata,
  output logic [NUM_REQ-1:0]       grant,
  output logic [NUM_REQ-1:0]       ack,
  output logic [BUS_W-1:0]         rdata,
  output logic [BUS_W-1:0]         mem_addr,
  output logic [BUS_W-1:0]         mem_wdata,
  output logic                     mem_r,
  output logic                     mem_w,
  input  logic [BUS_W-1:0]         mem_rdata
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [WAIT_CNT_W-1:0]  WAIT_INIT = WAIT_CNT_W'(WAIT_STATES);
  localparam logic [BURST_CNT_W-1:0] BURST_CAP = BURST_CNT_W'(MAX_BURST);
  localparam logic [IW-1:0]          LAST_INIT = IW'(NUM_REQ - 1);

  state_e                 state_q, state_d;
  logic [IW-1:0]          idx_q, idx_d;
  logic [IW-1:0]          last_q, last_d;
  logic [BUS_W-1:0]       latAddr_q, latAddr_d;
  logic [BUS_W-1:0]       latWdata_q, latWdata_d;
  logic                   latWe_q, latWe_d;
  logic [WAIT_CNT_W-1:0]  wait_q, wait_d;
  logic [BURST_CNT_W-1:0] burst_q, burst_d;
  logic [BUS_W-1:0]       rdata_q, rdata_d;

  logic [BUS_W-1:0] addrArr  [NUM_REQ];
  logic [BUS_W-1:0] wdataArr [NUM_REQ];
  logic [IW-1:0]    pickIdx;
  logic             pickValid;
  logic             burstOk;
  logic [NUM_REQ-1:0] idxOneHot;

  for (genvar g = 0; g < NUM_REQ; g++) begin : gUnpack
    assign addrArr[g]  = addr[g*BUS_W +: BUS_W];
    assign wdataArr[g] = wdata[g*BUS_W +: BUS_W];
  end

  arbiter_pick #(
    .NUM_REQ(NUM_REQ),
    .IW     (IW)
  ) uPick (
    .req_i         (req),
    .last_i        (last_q),
    .cpu_priority_i(CPU_PRIORITY != 0),
    .winner_o      (pickIdx),
    .valid_o       (pickValid)
  );

  assign burstOk = (MAX_BURST == 0) || (burst_q < BURST_CAP);

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    last_d     = last_q;
    latAddr_d  = latAddr_q;
    latWdata_d = latWdata_q;
    latWe_d    = latWe_q;
    wait_d     = wait_q;
    burst_d    = burst_q;
    rdata_d    = rdata_q;
    unique case (state_q)
      ST_IDLE: begin
        if (pickValid) begin
          idx_d      = pickIdx;
          latAddr_d  = addrArr[pickIdx];
          latWdata_d = wdataArr[pickIdx];
          latWe_d    = we[pickIdx];
          wait_d     = WAIT_INIT;
          burst_d    = BURST_CNT_W'(1);
          state_d    = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        if (wait_q != '0) begin
          wait_d = wait_q - 1'b1;
        end else begin
          if (!latWe_q) rdata_d = mem_rdata;
          state_d = ST_ACK;
        end
      end
      ST_ACK: begin
        last_d = idx_q;
        // A locked master keeps the bus only while it still requests and the
        // burst cap has room; otherwise everyone re-arbitrates from IDLE.
        if (lock[idx_q] && req[idx_q] && burstOk) begin
          latAddr_d  = addrArr[idx_q];
          latWdata_d = wdataArr[idx_q];
          latWe_d    = we[idx_q];
          wait_d     = WAIT_INIT;
          burst_d    = burst_q + 1'b1;
          state_d    = ST_ACCESS;
        end else begin
          burst_d = '0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      last_q     <= LAST_INIT;
      latAddr_q  <= '0;
      latWdata_q <= '0;
      latWe_q    <= 1'b0;
      wait_q     <= '0;
      burst_q    <= '0;
      rdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      last_q     <= last_d;
      latAddr_q  <= latAddr_d;
      latWdata_q <= latWdata_d;
      latWe_q    <= latWe_d;
      wait_q     <= wait_d;
      burst_q    <= burst_d;
      rdata_q    <= rdata_d;
    end
  end

  assign idxOneHot = {{(NUM_REQ-1){1'b0}}, 1'b1} << idx_q;
  assign grant     = (state_q != ST_IDLE) ? idxOneHot : '0;
  assign ack       = (state_q == ST_ACK) ? idxOneHot : '0;
  assign mem_addr  = latAddr_q;
  assign mem_wdata = latWdata_q;
  assign mem_r     = (state_q == ST_ACCESS) && !latWe_q;
  assign mem_w     = (state_q == ST_ACCESS) && latWe_q;
  assign rdata     = rdata_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Scoreboard bench for bus_arbiter: stimulus queues expected transfers, a
// negedge monitor checks every strobe cycle and every ack against them.
module tb_bus_arbiter;

  localparam int WS = 1;

  typedef struct {
    int          master;
    logic        we;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] rdata;
  } xfer_t;

  logic        clk;
  logic        reset;
  logic [3:0]  req, lock, we;
  logic [63:0] addr, wdata;
  logic [3:0]  grant, ack;
  logic [15:0] rdata, memAddr, memWdata, memRdata;
  logic        memR, memW;

  xfer_t sb[$];
  xfer_t monCur;
  int    total = 0;
  int    bad = 0;
  int    strobeCnt = 0;
  logic [3:0] seen;
  int    cyc;

  bus_arbiter #(
    .NUM_REQ(4), .WAIT_STATES(WS), .CPU_PRIORITY(1), .MAX_BURST(4)
  ) dut (
    .clk(clk), .reset(reset), .req(req), .lock(lock), .we(we),
    .addr(addr), .wdata(wdata), .grant(grant), .ack(ack), .rdata(rdata),
    .mem_addr(memAddr), .mem_wdata(memWdata), .mem_r(memR), .mem_w(memW),
    .mem_rdata(memRdata)
  );

  // Tiny memory: one known word, everything else reads back inverted address.
  assign memRdata = (memAddr == 16'h0123) ? 16'hBEEF : ~memAddr;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input int m, input logic w, input logic [15:0] a,
                               input logic [15:0] d, input logic r);
    req[m]          = r;
    we[m]           = w;
    addr[m*16 +: 16]  = a;
    wdata[m*16 +: 16] = d;
  endtask

  task automatic expectXfer(input int m, input logic w, input logic [15:0] a,
                            input logic [15:0] d, input logic [15:0] rd);
    xfer_t x;
    x.master = m; x.we = w; x.addr = a; x.wdata = d; x.rdata = rd;
    sb.push_back(x);
  endtask

  task automatic waitAck(output logic [3:0] s, output int n);
    s = '0;
    n = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (ack != 4'b0) begin
        s = ack;
        n = i;
        return;
      end
    end
    checkOutput("ackTimeout", 32'd0, 32'd1);
  endtask

  // Monitor: every strobe cycle must match the head transfer; every ack pops it.
  always @(negedge clk) begin
    if (reset) begin
      sb.delete();
      strobeCnt = 0;
    end else begin
      if (memR || memW) begin
        if (sb.size() == 0) begin
          checkOutput("unexpectedStrobe", 32'({memW, memR}), 32'd0);
        end else begin
          monCur = sb[0];
          strobeCnt++;
          checkOutput("strobeGrant", 32'(grant), 32'(4'b1 << monCur.master));
          checkOutput("memAddr", 32'(memAddr), 32'(monCur.addr));
          checkOutput("memW", 32'(memW), 32'(monCur.we));
          checkOutput("memR", 32'(memR), 32'(!monCur.we));
          if (monCur.we) checkOutput("memWdata", 32'(memWdata), 32'(monCur.wdata));
        end
      end
      if (ack != 4'b0) begin
        if (sb.size() == 0) begin
          checkOutput("unexpectedAck", 32'(ack), 32'd0);
        end else begin
          monCur = sb.pop_front();
          checkOutput("ackOwner", 32'(ack), 32'(4'b1 << monCur.master));
          checkOutput("ackGrant", 32'(grant), 32'(4'b1 << monCur.master));
          checkOutput("ackRdata", 32'(rdata), 32'(monCur.rdata));
          checkOutput("strobeCycles", 32'(strobeCnt), 32'(WS + 1));
          checkOutput("ackStrobesOff", 32'({memW, memR}), 32'd0);
          strobeCnt = 0;
        end
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset = 1'b1;
    req = '0; lock = '0; we = '0; addr = '0; wdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rstGrant", 32'(grant), 32'd0);
    checkOutput("rstAck", 32'(ack), 32'd0);
    checkOutput("rstMemR", 32'(memR), 32'd0);
    checkOutput("rstMemW", 32'(memW), 32'd0);
    checkOutput("rstMemAddr", 32'(memAddr), 32'd0);
    checkOutput("rstMemWdata", 32'(memWdata), 32'd0);
    checkOutput("rstRdata", 32'(rdata), 32'd0);
    @(posedge clk); #1 reset = 1'b0;
    @(posedge clk); #1;

    $display("[TB] cpu read");
    expectXfer(0, 1'b0, 16'h0123, 16'h0, 16'hBEEF);
    applyStimulus(0, 1'b0, 16'h0123, 16'h0, 1'b1);
    waitAck(seen, cyc);
    checkOutput("cpuReadAck", 32'(seen), 32'h1);
    checkOutput("cpuReadLatency", 32'(cyc), 32'(WS + 3));
    applyStimulus(0, 1'b0, 16'h0123, 16'h0, 1'b0);
    @(posedge clk); #1;

    $display("[TB] write");
    expectXfer(2, 1'b1, 16'h07FF, 16'h1234, 16'hBEEF);
    applyStimulus(2, 1'b1, 16'h07FF, 16'h1234, 1'b1);
    waitAck(seen, cyc);
    checkOutput("writeAck", 32'(seen), 32'h4);
    applyStimulus(2, 1'b0, 16'h07FF, 16'h1234, 1'b0);
    @(posedge clk); #1;

    $display("[TB] round robin");
    for (int i = 0; i < 2; i++) begin
      expectXfer(1, 1'b0, 16'h1100, 16'h0, 16'hEEFF);
      expectXfer(2, 1'b0, 16'h2200, 16'h0, 16'hDDFF);
    end
    applyStimulus(1, 1'b0, 16'h1100, 16'h0, 1'b1);
    applyStimulus(2, 1'b0, 16'h2200, 16'h0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      waitAck(seen, cyc);
      checkOutput("rrOrder", 32'(seen), (i % 2 == 0) ? 32'h2 : 32'h4);
    end
    applyStimulus(1, 1'b0, 16'h1100, 16'h0, 1'b0);
    applyStimulus(2, 1'b0, 16'h2200, 16'h0, 1'b0);
    @(posedge clk); #1;

    $display("[TB] cpu priority");
    for (int i = 0; i < 3; i++) expectXfer(0, 1'b0, 16'h0040, 16'h0, 16'hFFBF);
    expectXfer(3, 1'b0, 16'h3300, 16'h0, 16'hCCFF);
    applyStimulus(0, 1'b0, 16'h0040, 16'h0, 1'b1);
    applyStimulus(3, 1'b0, 16'h3300, 16'h0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      waitAck(seen, cyc);
      if (i == 2) applyStimulus(0, 1'b0, 16'h0040, 16'h0, 1'b0);
      if (i == 3) applyStimulus(3, 1'b0, 16'h3300, 16'h0, 1'b0);
    end
    @(posedge clk); #1;

    $display("[TB] locked burst");
    for (int i = 0; i < 4; i++) expectXfer(1, 1'b0, 16'h1000 + 16'(i), 16'h0, ~(16'h1000 + 16'(i)));
    expectXfer(2, 1'b0, 16'h2200, 16'h0, 16'hDDFF);
    expectXfer(1, 1'b0, 16'h1004, 16'h0, 16'hEFFB);
    expectXfer(1, 1'b0, 16'h1005, 16'h0, 16'hEFFA);
    lock[1] = 1'b1;
    applyStimulus(1, 1'b0, 16'h1000, 16'h0, 1'b1);
    applyStimulus(2, 1'b0, 16'h2200, 16'h0, 1'b1);
    for (int i = 0; i < 7; i++) begin
      waitAck(seen, cyc);
      case (i)
        0, 1, 2: applyStimulus(1, 1'b0, 16'h1000 + 16'(i + 1), 16'h0, 1'b1);
        3: begin
          applyStimulus(1, 1'b0, 16'h1004, 16'h0, 1'b1);
          @(negedge clk);
          checkOutput("burstCapIdle", 32'(grant), 32'd0);
        end
        4: applyStimulus(2, 1'b0, 16'h2200, 16'h0, 1'b0);
        5: applyStimulus(1, 1'b0, 16'h1005, 16'h0, 1'b1);
        default: begin
          applyStimulus(1, 1'b0, 16'h1005, 16'h0, 1'b0);
          lock[1] = 1'b0;
        end
      endcase
    end
    @(posedge clk); #1;

    $display("[TB] reset during access");
    expectXfer(0, 1'b0, 16'h0055, 16'h0, 16'hFFAA);
    applyStimulus(0, 1'b0, 16'h0055, 16'h0, 1'b1);
    @(posedge clk); #1;
    reset = 1'b1;
    applyStimulus(0, 1'b0, 16'h0055, 16'h0, 1'b0);
    @(negedge clk);
    checkOutput("rstPreStrobe", 32'(memR), 32'd1);
    @(negedge clk);
    checkOutput("rstMidGrant", 32'(grant), 32'd0);
    checkOutput("rstMidAck", 32'(ack), 32'd0);
    checkOutput("rstMidMemR", 32'(memR), 32'd0);
    checkOutput("rstMidMemW", 32'(memW), 32'd0);
    @(posedge clk); #1 reset = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    expectXfer(0, 1'b0, 16'h0123, 16'h0, 16'hBEEF);
    applyStimulus(0, 1'b0, 16'h0123, 16'h0, 1'b1);
    waitAck(seen, cyc);
    checkOutput("postRstAck", 32'(seen), 32'h1);
    checkOutput("postRstLatency", 32'(cyc), 32'(WS + 3));
    applyStimulus(0, 1'b0, 16'h0123, 16'h0, 1'b0);

    repeat (3) @(posedge clk);
    checkOutput("queueEmpty", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
